// File: rtl/vram_pkg.sv
// -----------------------------------------------------------------------------
// vram_pkg
// Shared types and sizes for the VRAM write-port arbiter.
//   VRAM_ADDR_W / VRAM_DATA_W : default VRAM address and data widths
//   fill_state_t              : fill engine states
//   grant_t                   : identity of the most recent write-port owner
// -----------------------------------------------------------------------------
package vram_pkg;

   localparam int VRAM_ADDR_W = 10;
   localparam int VRAM_DATA_W = 8;

   typedef enum logic [1:0] {IDLE, ARMED, FILL, DONE} fill_state_t;

   typedef enum logic {GRANT_CPU, GRANT_FILL} grant_t;

endpackage

// File: rtl/vsync_edge_sync.sv
// -----------------------------------------------------------------------------
// vsync_edge_sync
// Brings the asynchronous vsync into the clk domain through two flops and
// produces a one-cycle pulse on each synchronised rising edge.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   async_i : asynchronous level input (vsync)
//   rise_o  : one-cycle pulse, high while the synchronised level first reads 1
// -----------------------------------------------------------------------------
module vsync_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   // Only the metastability-safe stages feed the edge detector.
   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/vram_write_arbiter.sv
// -----------------------------------------------------------------------------
// vram_write_arbiter
// Shares the single VRAM write port between CPU stores and a fill/clear
// engine. A fill is armed by fill_start, begins on the next vsync rising edge
// and then alternates fairly with CPU writes until the range is written.
//   clk, rst                     : clock, synchronous active-high reset
//   vsync                        : asynchronous frame sync
//   cpu_req/cpu_addr/cpu_data    : CPU write request (level) and payload
//   cpu_ack                      : one-cycle pulse coincident with the CPU write
//   fill_start/base/len/value    : arm a fill (parameters sampled with start)
//   fill_busy, fill_done         : fill in progress / one-cycle completion
//   v_cea/v_ada/v_din            : registered VRAM write port
// -----------------------------------------------------------------------------
module vram_write_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_ack,
   input  logic              fill_start,
   input  logic [ADDR_W-1:0] fill_base,
   input  logic [ADDR_W:0]   fill_len,
   input  logic [DATA_W-1:0] fill_value,
   output logic              fill_busy,
   output logic              fill_done,
   output logic              v_cea,
   output logic [ADDR_W-1:0] v_ada,
   output logic [DATA_W-1:0] v_din
);

   localparam logic [ADDR_W:0] LAST_WORD = {{ADDR_W{1'b0}}, 1'b1};

   fill_state_t       state_q, state_d;
   grant_t            last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [DATA_W-1:0] val_q, val_d;
   logic              cea_q, cea_d;
   logic [ADDR_W-1:0] ada_q, ada_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              ack_q, ack_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic vs_rise;
   logic cpu_elig;
   logic fill_elig;
   logic grant_cpu;
   logic grant_fill;

   vsync_edge_sync u_vsync (
      .clk     (clk),
      .rst     (rst),
      .async_i (vsync),
      .rise_o  (vs_rise)
   );

   // Arbitration. A CPU request is not eligible while its ack is showing,
   // so a held request cannot be written twice.
   always_comb begin
      cpu_elig   = cpu_req & ~ack_q;
      fill_elig  = (state_q == FILL) && (rem_q != '0);
      grant_cpu  = 1'b0;
      grant_fill = 1'b0;
      if (cpu_elig && fill_elig) begin
         if (last_grant_q == GRANT_FILL) grant_cpu  = 1'b1;
         else                            grant_fill = 1'b1;
      end else begin
         grant_cpu  = cpu_elig;
         grant_fill = fill_elig;
      end
   end

   // Next-state, datapath and output computation.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      ptr_d        = ptr_q;
      rem_d        = rem_q;
      val_d        = val_q;
      cea_d        = 1'b0;
      ada_d        = ada_q;   // address/data hold when the port is idle
      din_d        = din_q;
      ack_d        = 1'b0;

      if (grant_cpu) begin
         cea_d        = 1'b1;
         ada_d        = cpu_addr;
         din_d        = cpu_data;
         ack_d        = 1'b1;
         last_grant_d = GRANT_CPU;
      end else if (grant_fill) begin
         cea_d        = 1'b1;
         ada_d        = ptr_q;
         din_d        = val_q;
         ptr_d        = ptr_q + 1'b1;   // natural wrap at the top address
         rem_d        = rem_q - 1'b1;
         last_grant_d = GRANT_FILL;
      end

      case (state_q)
         IDLE: begin
            if (fill_start) begin
               ptr_d   = fill_base;
               rem_d   = fill_len;
               val_d   = fill_value;
               state_d = (fill_len == '0) ? DONE : ARMED;
            end
         end
         ARMED: begin
            if (vs_rise) state_d = FILL;
         end
         FILL: begin
            if (grant_fill && (rem_q == LAST_WORD)) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status outputs are registered copies of the state being entered,
      // so fill_done and the fall of fill_busy line up with DONE.
      busy_d = (state_d == ARMED) || (state_d == FILL);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_FILL;
         ptr_q        <= '0;
         rem_q        <= '0;
         val_q        <= '0;
         cea_q        <= 1'b0;
         ada_q        <= '0;
         din_q        <= '0;
         ack_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         ptr_q        <= ptr_d;
         rem_q        <= rem_d;
         val_q        <= val_d;
         cea_q        <= cea_d;
         ada_q        <= ada_d;
         din_q        <= din_d;
         ack_q        <= ack_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign v_cea     = cea_q;
   assign v_ada     = ada_q;
   assign v_din     = din_q;
   assign cpu_ack   = ack_q;
   assign fill_busy = busy_q;
   assign fill_done = done_q;

endmodule
